// File: rtl/ft_restore.sv
// Fault-tolerance restore sequencer: halts lockstep cores, replays the shadow GPRs into the
// core register file, reloads the last known-good PC and pulses resume.
module ft_restore #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int SKIP_R0    = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  error_i,
   input  logic [DATA_WIDTH-1:0] spc_i,
   input  logic                  core_halted_i,
   output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
   input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
   output logic                  rf_we_o,
   output logic [ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  pc_set_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  halt_o,
   output logic                  resume_o,
   output logic                  busy_o,
   output logic [7:0]            recovery_cnt_o
);

   // One extra index bit so the sweep never wraps when NUM_REGS == 2**ADDR_WIDTH.
   localparam int IW = ADDR_WIDTH + 1;
   localparam logic [IW-1:0] FIRST = (SKIP_R0 != 0) ? IW'(1) : '0;
   localparam logic [IW-1:0] LAST  = IW'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_RESTORE,
      S_SETPC,
      S_RESUME
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   rf_we_q, rf_we_d;
   logic [ADDR_WIDTH-1:0]  rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0]  rf_wdata_q, rf_wdata_d;
   logic [DATA_WIDTH-1:0]  pc_q, pc_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   halt_q, halt_d;
   logic                   pc_set_q, pc_set_d;
   logic                   resume_q, resume_d;
   logic                   busy_q, busy_d;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rf_we_d    = rf_we_q;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      pc_d       = pc_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (error_i) begin
               state_d = S_HALT;
               pc_d    = spc_i;
               if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
         end
         S_HALT: begin
            if (core_halted_i) begin
               state_d = S_RESTORE;
               idx_d   = FIRST;
            end
         end
         S_RESTORE: begin
            // Read data is combinational from sgpr_raddr_o, so the write lands one cycle later.
            rf_we_d    = 1'b1;
            rf_waddr_d = idx_q[ADDR_WIDTH-1:0];
            rf_wdata_d = sgpr_rdata_i;
            idx_d      = idx_q + IW'(1);
            if (idx_q == LAST) state_d = S_SETPC;
         end
         S_SETPC: begin
            state_d = S_RESUME;
            rf_we_d = 1'b0;
         end
         S_RESUME: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Status outputs are registered from the next state so they line up with state_q.
      halt_d   = (state_d == S_HALT) || (state_d == S_RESTORE) || (state_d == S_SETPC);
      pc_set_d = (state_d == S_SETPC);
      resume_d = (state_d == S_RESUME);
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         pc_q       <= '0;
         cnt_q      <= '0;
         halt_q     <= 1'b0;
         pc_set_q   <= 1'b0;
         resume_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         pc_q       <= pc_d;
         cnt_q      <= cnt_d;
         halt_q     <= halt_d;
         pc_set_q   <= pc_set_d;
         resume_q   <= resume_d;
         busy_q     <= busy_d;
      end
   end

   assign sgpr_raddr_o   = (state_q == S_RESTORE) ? idx_q[ADDR_WIDTH-1:0] : '0;
   assign rf_we_o        = rf_we_q;
   assign rf_waddr_o     = rf_waddr_q;
   assign rf_wdata_o     = rf_wdata_q;
   assign pc_set_o       = pc_set_q;
   assign pc_o           = pc_q;
   assign halt_o         = halt_q;
   assign resume_o       = resume_q;
   assign busy_o         = busy_q;
   assign recovery_cnt_o = cnt_q;

endmodule

// File: tb/tb_ft_restore.sv
// Bench for ft_restore: two instances (x0 skipped / x0 restored) driven through directed
// recoveries with randomized shadow-register contents, PCs and halt-acknowledge delays.
module tb_ft_restore;

   logic        clk;
   logic        rst_n;
   logic        core_halted;
   logic [31:0] spc;
   logic        err      [2];
   logic [4:0]  raddr    [2];
   logic [31:0] rdata    [2];
   logic        rf_we    [2];
   logic [4:0]  waddr    [2];
   logic [31:0] wdata    [2];
   logic        pc_set   [2];
   logic [31:0] pc       [2];
   logic        halt     [2];
   logic        resume   [2];
   logic        busy     [2];
   logic [7:0]  cnt      [2];

   logic [31:0] mem [32];
   int          total = 0;
   int          bad   = 0;
   int          cnt_m [2];

   ft_restore #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(32), .SKIP_R0(1)) dut_a (
      .clk_i(clk), .rst_n(rst_n), .error_i(err[0]), .spc_i(spc),
      .core_halted_i(core_halted), .sgpr_raddr_o(raddr[0]), .sgpr_rdata_i(rdata[0]),
      .rf_we_o(rf_we[0]), .rf_waddr_o(waddr[0]), .rf_wdata_o(wdata[0]),
      .pc_set_o(pc_set[0]), .pc_o(pc[0]), .halt_o(halt[0]), .resume_o(resume[0]),
      .busy_o(busy[0]), .recovery_cnt_o(cnt[0]));

   ft_restore #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(32), .SKIP_R0(0)) dut_b (
      .clk_i(clk), .rst_n(rst_n), .error_i(err[1]), .spc_i(spc),
      .core_halted_i(core_halted), .sgpr_raddr_o(raddr[1]), .sgpr_rdata_i(rdata[1]),
      .rf_we_o(rf_we[1]), .rf_waddr_o(waddr[1]), .rf_wdata_o(wdata[1]),
      .pc_set_o(pc_set[1]), .pc_o(pc[1]), .halt_o(halt[1]), .resume_o(resume[1]),
      .busy_o(busy[1]), .recovery_cnt_o(cnt[1]));

   // Shadow register file model: combinational read.
   assign rdata[0] = mem[raddr[0]];
   assign rdata[1] = mem[raddr[1]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ctrl(input int s);
      return 64'({rf_we[s], waddr[s], pc_set[s], halt[s], resume[s], busy[s], cnt[s], raddr[s]});
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
   endtask

   // One full recovery on instance s with h HALT cycles; abort_at >= 0 pulls reset when the
   // sweep is reading that address.
   task automatic recover(input int s, input int h, input logic [31:0] pcv, input bit hold,
                          input int abort_at);
      int first;
      int n;
      first = (s == 0) ? 1 : 0;
      n     = 32 - first;
      err[s] = 1'b1;
      spc = pcv;
      core_halted = 1'b0;
      tick();
      cnt_m[s] = (cnt_m[s] < 255) ? cnt_m[s] + 1 : 255;
      check("halt_busy", 64'(busy[s]), 64'd1);
      check("halt_halt", 64'(halt[s]), 64'd1);
      check("halt_pc", 64'(pc[s]), 64'(pcv));
      check("halt_cnt", 64'(cnt[s]), 64'(cnt_m[s]));
      check("halt_raddr", 64'(raddr[s]), 64'd0);
      if (!hold) err[s] = 1'b0;
      for (int i = 1; i < h; i++) begin
         tick();
         check("halt_wait_halt", 64'(halt[s]), 64'd1);
         check("halt_wait_we", 64'(rf_we[s]), 64'd0);
         check("halt_wait_raddr", 64'(raddr[s]), 64'd0);
      end
      core_halted = 1'b1;
      for (int k = 0; k < n; k++) begin
         tick();
         if (k == 1) core_halted = 1'b0;
         if (k == 2) spc = 32'hDEAD_BEEF;
         check("rst_raddr", 64'(raddr[s]), 64'(first + k));
         check("rst_halt", 64'(halt[s]), 64'd1);
         check("rst_pcset_resume", 64'({pc_set[s], resume[s]}), 64'd0);
         check("rst_pc_stable", 64'(pc[s]), 64'(pcv));
         if (k == 0) begin
            check("rst_first_we", 64'(rf_we[s]), 64'd0);
         end else begin
            check("rst_we", 64'(rf_we[s]), 64'd1);
            check("rst_waddr", 64'(waddr[s]), 64'(first + k - 1));
            check("rst_wdata", 64'(wdata[s]), 64'(mem[first + k - 1]));
         end
         if (first + k == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            cnt_m[0] = 0;
            cnt_m[1] = 0;
            check("abort_ctrl", ctrl(s), 64'd0);
            check("abort_wdata", 64'(wdata[s]), 64'd0);
            check("abort_pc", 64'(pc[s]), 64'd0);
            err[s] = 1'b0;
            for (int j = 0; j < 3; j++) begin
               tick();
               check("abort_held_ctrl", ctrl(s), 64'd0);
            end
            rst_n = 1'b1;
            for (int j = 0; j < 3; j++) begin
               tick();
               check("abort_after_ctrl", ctrl(s), 64'd0);
            end
            return;
         end
      end
      tick();
      check("setpc_pcset", 64'(pc_set[s]), 64'd1);
      check("setpc_halt", 64'(halt[s]), 64'd1);
      check("setpc_pc", 64'(pc[s]), 64'(pcv));
      check("setpc_we", 64'(rf_we[s]), 64'd1);
      check("setpc_waddr", 64'(waddr[s]), 64'd31);
      check("setpc_wdata", 64'(wdata[s]), 64'(mem[31]));
      check("setpc_raddr", 64'(raddr[s]), 64'd0);
      check("setpc_resume", 64'(resume[s]), 64'd0);
      tick();
      check("resume_pulse", 64'(resume[s]), 64'd1);
      check("resume_halt", 64'(halt[s]), 64'd0);
      check("resume_pcset", 64'(pc_set[s]), 64'd0);
      check("resume_we", 64'(rf_we[s]), 64'd0);
      check("resume_hold_waddr", 64'(waddr[s]), 64'd31);
      check("resume_busy", 64'(busy[s]), 64'd1);
      tick();
      check("idle_busy", 64'(busy[s]), 64'd0);
      check("idle_resume", 64'(resume[s]), 64'd0);
      check("idle_halt", 64'(halt[s]), 64'd0);
      check("idle_pc_kept", 64'(pc[s]), 64'(pcv));
      check("idle_cnt", 64'(cnt[s]), 64'(cnt_m[s]));
   endtask

   initial begin
      rst_n = 1'b0;
      err[0] = 1'b0;
      err[1] = 1'b0;
      core_halted = 1'b0;
      spc = '0;
      cnt_m[0] = 0;
      cnt_m[1] = 0;
      fill_random();
      #3;
      check("reset_ctrl_a", ctrl(0), 64'd0);
      check("reset_pc_a", 64'(pc[0]), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Quiet operation with error low.
      for (int i = 0; i < 20; i++) begin
         tick();
         check("quiet_ctrl_a", ctrl(0), 64'd0);
         check("quiet_ctrl_b", ctrl(1), 64'd0);
      end
      check("quiet_wdata", 64'(wdata[0]), 64'd0);
      check("quiet_pc", 64'(pc[0]), 64'd0);

      // Recognisable shadow contents, x0 skipped, halt acknowledged after 3 cycles.
      for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
      recover(0, 3, 32'h0000_0100, 1'b0, -1);

      // Instance restoring x0 as well.
      fill_random();
      recover(1, 2, $urandom, 1'b0, -1);
      check("b_cnt", 64'(cnt[1]), 64'd1);

      // Error held high: back-to-back recoveries, then drive the counter into saturation.
      fill_random();
      for (int r = 0; r < 3; r++) recover(0, int'($urandom_range(1, 4)), $urandom, 1'b1, -1);
      for (int r = 0; r < 256; r++) recover(0, 1, $urandom, 1'b1, -1);
      err[0] = 1'b0;
      check("cnt_saturated", 64'(cnt[0]), 64'd255);
      tick();
      check("no_restart_after_err_low", 64'(busy[0]), 64'd0);

      // Reset in the middle of the sweep, then a clean recovery afterwards.
      fill_random();
      recover(0, 2, $urandom, 1'b0, 10);
      fill_random();
      recover(0, int'($urandom_range(1, 5)), $urandom, 1'b0, -1);
      check("cnt_after_reset", 64'(cnt[0]), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
